// File: rtl/fmul32_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
package fmul32_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned SIG_W    = MANT_W + 1;
  localparam int unsigned PROD_W   = 2 * SIG_W;
  localparam int unsigned EXPT_W   = 10;
  localparam int unsigned FLAG_W   = 5;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

  // Bit positions inside flags = {invalid, overflow, underflow, inexact, special}
  localparam int unsigned FLG_INVALID   = 4;
  localparam int unsigned FLG_OVERFLOW  = 3;
  localparam int unsigned FLG_UNDERFLOW = 2;
  localparam int unsigned FLG_INEXACT   = 1;
  localparam int unsigned FLG_SPECIAL   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UNPACK = 3'd1,
    ST_MUL    = 3'd2,
    ST_NORM   = 3'd3,
    ST_ROUND  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, EXP_MAX, MANT_W'(0)};
  endfunction

  function automatic logic [31:0] fp_zero(input logic sign);
    return {sign, 31'(0)};
  endfunction

endpackage

// File: rtl/fmul32_round_pack.sv
// Combinational RNE rounding, range check and binary32 packing of a normalised significand.
module fmul32_round_pack
  import fmul32_pkg::*;
#(
  parameter bit FTZ = 1'b1
) (
  input  logic                     sign_i,
  input  logic signed [EXPT_W-1:0] exp_i,
  input  logic [SIG_W-1:0]         sig_i,
  input  logic [2:0]               grs_i,
  output logic [31:0]              result_c,
  output logic [FLAG_W-1:0]        flags_c
);

  localparam int unsigned EXT_W  = SIG_W + 3;
  localparam int unsigned SUM_W  = SIG_W + 1;
  localparam int unsigned SH_MAX = EXT_W - 1;
  localparam logic signed [EXPT_W-1:0] EXP_ONE = EXPT_W'(1);
  localparam logic signed [EXPT_W-1:0] EXP_OVF = EXPT_W'(255);

  logic [EXPT_W-1:0]        sh;
  logic [EXT_W-1:0]         ext_sh;
  logic [SIG_W-1:0]         sig;
  logic                     g, rs, lost, inc, denorm, inexact;
  logic [SUM_W-1:0]         sum;
  logic signed [EXPT_W-1:0] exp_r;

  always_comb begin
    sh     = '0;
    ext_sh = {sig_i, grs_i};
    lost   = 1'b0;
    denorm = 1'b0;
    // Gradual underflow: denormalise before rounding so the sticky sees every lost bit
    if (!FTZ && (exp_i < EXP_ONE)) begin
      denorm = 1'b1;
      sh     = EXPT_W'(EXP_ONE - exp_i);
      if (sh > EXPT_W'(SH_MAX)) sh = EXPT_W'(SH_MAX);
      ext_sh = {sig_i, grs_i} >> sh;
      lost   = |({sig_i, grs_i} & ~({EXT_W{1'b1}} << sh));
    end

    sig     = ext_sh[EXT_W-1:3];
    g       = ext_sh[2];
    rs      = (|ext_sh[1:0]) | lost;
    inc     = g & (rs | sig[0]);
    sum     = {1'b0, sig} + SUM_W'(inc);
    exp_r   = exp_i + EXPT_W'(sum[SIG_W]);
    inexact = g | rs;

    flags_c  = '0;
    result_c = {sign_i, exp_r[EXP_W-1:0],
                sum[SIG_W] ? sum[SIG_W-1:1] : sum[MANT_W-1:0]};

    if (denorm) begin
      // A round-up into the hidden bit lands naturally on the smallest normal encoding
      result_c                 = {sign_i, {(EXP_W-1){1'b0}}, sum[SIG_W-1:0]};
      flags_c[FLG_UNDERFLOW]   = inexact;
      flags_c[FLG_INEXACT]     = inexact;
    end else if (exp_r >= EXP_OVF) begin
      result_c                 = fp_inf(sign_i);
      flags_c[FLG_OVERFLOW]    = 1'b1;
      flags_c[FLG_INEXACT]     = 1'b1;
    end else if (exp_r < EXP_ONE) begin
      result_c                 = fp_zero(sign_i);
      flags_c[FLG_UNDERFLOW]   = 1'b1;
      flags_c[FLG_INEXACT]     = 1'b1;
    end else begin
      flags_c[FLG_INEXACT]     = inexact;
    end
  end

endmodule

// File: rtl/fmul32_seq_ctrl.sv
// Multi-cycle binary32 multiplier: valid/ready in, unpack, shift-add multiply, normalise, round, valid/ready out.
module fmul32_seq_ctrl
  import fmul32_pkg::*;
#(
  parameter int unsigned BITS_PER_CYC = 1,
  parameter bit          FTZ          = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);

  localparam int unsigned STEPS = SIG_W / BITS_PER_CYC;
  localparam int unsigned PP_W  = SIG_W + BITS_PER_CYC;
  localparam int unsigned ACC_W = PROD_W + BITS_PER_CYC;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  fp32_t                    a_q, a_d, b_q, b_d;
  logic                     sign_q, sign_d;
  logic signed [EXPT_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0]         mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic [PROD_W-1:0]        prod_q, prod_d;
  logic [SIG_W-1:0]         sig_q, sig_d;
  logic [2:0]               grs_q, grs_d;
  logic [31:0]              result_q, result_d;
  logic [FLAG_W-1:0]        flags_q, flags_d;
  logic                     in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

  logic                     sign_c, hid_a_c, hid_b_c, spec_c;
  logic                     zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
  logic [EXP_W-1:0]         ea_eff_c, eb_eff_c;
  logic [31:0]              spec_res_c, rp_result_c;
  logic [FLAG_W-1:0]        spec_flags_c, rp_flags_c;
  logic [PP_W-1:0]          pp_c;
  logic [ACC_W-1:0]         acc_sum_c;

  // Operand classification of the latched pair
  always_comb begin
    sign_c   = a_q.sign ^ b_q.sign;
    hid_a_c  = (a_q.exp != '0);
    hid_b_c  = (b_q.exp != '0);
    ea_eff_c = hid_a_c ? a_q.exp : EXP_W'(1);
    eb_eff_c = hid_b_c ? b_q.exp : EXP_W'(1);
    zero_a   = !hid_a_c && (FTZ || (a_q.mant == '0));
    zero_b   = !hid_b_c && (FTZ || (b_q.mant == '0));
    inf_a    = (a_q.exp == EXP_MAX) && (a_q.mant == '0);
    inf_b    = (b_q.exp == EXP_MAX) && (b_q.mant == '0);
    nan_a    = (a_q.exp == EXP_MAX) && (a_q.mant != '0);
    nan_b    = (b_q.exp == EXP_MAX) && (b_q.mant != '0);
    snan_a   = nan_a && !a_q.mant[MANT_W-1];
    snan_b   = nan_b && !b_q.mant[MANT_W-1];
    spec_c   = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;

    spec_flags_c              = '0;
    spec_flags_c[FLG_SPECIAL] = 1'b1;
    if (nan_a || nan_b) begin
      spec_res_c                = QNAN;
      spec_flags_c[FLG_INVALID] = snan_a | snan_b;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      spec_res_c                = QNAN;
      spec_flags_c[FLG_INVALID] = 1'b1;
    end else if (inf_a || inf_b) begin
      spec_res_c = fp_inf(sign_c);
    end else begin
      spec_res_c = fp_zero(sign_c);
    end
  end

  // Shared partial-product adder: retire BITS_PER_CYC multiplier bits, accumulator shifts right
  assign pp_c      = {{BITS_PER_CYC{1'b0}}, mant_a_q} * {{SIG_W{1'b0}}, mant_b_q[BITS_PER_CYC-1:0]};
  assign acc_sum_c = {{BITS_PER_CYC{1'b0}}, prod_q} + {pp_c, {SIG_W{1'b0}}};

  fmul32_round_pack #(.FTZ(FTZ)) u_round_pack (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .sig_i    (sig_q),
    .grs_i    (grs_q),
    .result_c (rp_result_c),
    .flags_c  (rp_flags_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_a_d = mant_a_q;
    mant_b_d = mant_b_q;
    prod_d   = prod_q;
    sig_d    = sig_q;
    grs_d    = grs_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        sign_d   = sign_c;
        exp_d    = EXPT_W'(ea_eff_c) + EXPT_W'(eb_eff_c) - EXPT_W'(EXP_BIAS);
        mant_a_d = {hid_a_c, a_q.mant};
        mant_b_d = {hid_b_c, b_q.mant};
        prod_d   = '0;
        cnt_d    = '0;
        if (spec_c) begin
          result_d = spec_res_c;
          flags_d  = spec_flags_c;
          state_d  = ST_DONE;
        end else begin
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        prod_d   = PROD_W'(acc_sum_c >> BITS_PER_CYC);
        mant_b_d = mant_b_q >> BITS_PER_CYC;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          cnt_d   = '0;
          state_d = ST_NORM;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_NORM: begin
        if (prod_q[PROD_W-1]) begin
          sig_d = prod_q[PROD_W-1:SIG_W];
          grs_d = {prod_q[SIG_W-1], prod_q[SIG_W-2], |prod_q[SIG_W-3:0]};
          exp_d = exp_q + EXPT_W'(1);
        end else begin
          sig_d = prod_q[PROD_W-2:SIG_W-1];
          grs_d = {prod_q[SIG_W-2], prod_q[SIG_W-3], |prod_q[SIG_W-4:0]};
        end
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        result_d = rp_result_c;
        flags_d  = rp_flags_c;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready && out_valid_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_a_q    <= '0;
      mant_b_q    <= '0;
      prod_q      <= '0;
      sig_q       <= '0;
      grs_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_a_q    <= mant_a_d;
      mant_b_q    <= mant_b_d;
      prod_q      <= prod_d;
      sig_q       <= sig_d;
      grs_q       <= grs_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fmul32_seq_ctrl.sv
// Directed bench for fmul32_seq_ctrl with an integer-arithmetic reference model and a per-cycle scoreboard.
module tb_fmul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, in_ready, out_valid, busy;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fmul32_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  // Reference: exact integer product, round by comparing the remainder with one half ulp
  function automatic logic [36:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic s, inx, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    longint ma, mb, p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0];        fb = b[22:0];
    nan_a  = (ea == 255) && (fa != 0);  nan_b  = (eb == 255) && (fb != 0);
    inf_a  = (ea == 255) && (fa == 0);  inf_b  = (eb == 255) && (fb == 0);
    zero_a = (ea == 0);                 zero_b = (eb == 0);
    if (nan_a || nan_b)
      return {(nan_a && !fa[22]) || (nan_b && !fb[22]), 3'b000, 1'b1, 32'h7FC00000};
    if ((inf_a && zero_b) || (zero_a && inf_b)) return {5'b10001, 32'h7FC00000};
    if (inf_a || inf_b)   return {5'b00001, s, 8'hFF, 23'h0};
    if (zero_a || zero_b) return {5'b00001, s, 31'h0};
    ma = longint'(fa) + (longint'(1) << 23);
    mb = longint'(fb) + (longint'(1) << 23);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
    inx = (rem != 0);
    if (e >= 255) return {5'b01010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {5'b00110, s, 31'h0};
    return {3'b000, inx, 1'b0, s, e[7:0], q[22:0]};
  endfunction

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: expectation pushed at accept, compared every cycle out_valid is high
  logic [36:0] sb_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (!out_valid || result !== hold_res) begin
          failures++;
          $display("FAIL hold_stable valid=%b result=%h expected valid=1 result=%h", out_valid, result, hold_res);
        end
      end
      if (out_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_out_valid result=%h expected no output", result);
        end else if ({flags, result} !== sb_q[0]) begin
          failures++;
          $display("FAIL scoreboard flags/result=%h/%h expected=%h/%h",
                   flags, result, sb_q[0][36:32], sb_q[0][31:0]);
        end
        hold_pend = !out_ready;
        hold_res  = result;
        if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
      end else begin
        hold_pend = 1'b0;
      end
      if (in_valid && in_ready) sb_q.push_back(fmul_ref(op_a, op_b));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      failures++; checks++;
      $display("FAIL in_ready_timeout in_ready=0 expected 1 within 200 cycles");
    end
    in_valid = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin
      failures++; checks++;
      $display("FAIL out_valid_timeout out_valid=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [4:0] exp_flg, input int exp_lat);
    int lat;
    chk({name, "_model"}, fmul_ref(a, b), {exp_flg, exp_res});
    send(a, b);
    chk({name, "_busy"}, {36'd0, busy}, 37'd1);
    wait_result(lat);
    chk({name, "_result"}, {5'd0, result}, {5'd0, exp_res});
    chk({name, "_flags"}, {32'd0, flags}, {32'd0, exp_flg});
    if (exp_lat > 0) chk({name, "_latency"}, 37'(lat), 37'(exp_lat));
    chk({name, "_in_ready_hs"}, {36'd0, in_ready}, 37'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_model(input logic [31:0] a, input logic [31:0] b);
    int lat;
    send(a, b);
    wait_result(lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {36'd0, in_ready},  37'd1);
    chk("rst_out_valid", {36'd0, out_valid}, 37'd0);
    chk("rst_result",    {5'd0, result},     37'd0);
    chk("rst_flags",     {32'd0, flags},     37'd0);
    chk("rst_busy",      {36'd0, busy},      37'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec("t1_one",       32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 27);
    run_vec("t2_norm",      32'h3FC00000, 32'h3FC00000, 32'h40100000, 5'b00000, 27);
    run_vec("t3_sticky",    32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00010, 27);
    run_vec("t4_inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10001, 1);
    run_vec("t5_overflow",  32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 5'b01010, 27);
    run_vec("t5_underflow", 32'h00800000, 32'h00800000, 32'h00000000, 5'b00110, 27);
    run_vec("neg_half",     32'hC0000000, 32'h3F000000, 32'hBF800000, 5'b00000, 27);
    run_vec("min_normal",   32'h3F800000, 32'h00800000, 32'h00800000, 5'b00000, 27);
    run_vec("snan",         32'h7FA00000, 32'h3F800000, 32'h7FC00000, 5'b10001, 1);
    run_vec("qnan",         32'h7FC00001, 32'h00000000, 32'h7FC00000, 5'b00001, 1);
    run_vec("neg_inf",      32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00001, 1);
    run_vec("neg_zero",     32'h80000000, 32'h40A00000, 32'h80000000, 5'b00001, 1);
    run_vec("daz",          32'h00400000, 32'h7F000000, 32'h00000000, 5'b00001, 1);

    run_model(32'h40490FDB, 32'h402DF854);
    run_model(32'h3FFFFFFF, 32'h3FFFFFFF);
    run_model(32'hC1234567, 32'h4089ABCD);
    run_model(32'h1F800000, 32'h1F800000);

    // Backpressure: result held for 10 cycles with no new accept
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid",    {36'd0, out_valid}, 37'd1);
      chk("bp_result",   {5'd0, result},     {5'd0, 32'h3F800000});
      chk("bp_in_ready", {36'd0, in_ready},  37'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_valid",    {36'd0, out_valid}, 37'd0);
    chk("bp_after_in_ready", {36'd0, in_ready},  37'd1);

    // Reset mid-multiply discards the operation
    send(32'h3FC00000, 32'h40400000);
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  {36'd0, in_ready},  37'd1);
    chk("midrst_out_valid", {36'd0, out_valid}, 37'd0);
    chk("midrst_result",    {5'd0, result},     37'd0);
    chk("midrst_flags",     {32'd0, flags},     37'd0);
    chk("midrst_busy",      {36'd0, busy},      37'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 37'(seen), 37'd0);
    run_vec("post_rst", 32'h3FC00000, 32'h40400000, 32'h40900000, 5'b00000, 27);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 37'(sb_q.size()), 37'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
